// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, state encoding and default idle byte for the SPI slave
package spi_pkg;
  localparam int SPI_BYTE_W = 8;
  localparam int SPI_BIT_CNT_W = 3;
  localparam logic [SPI_BYTE_W-1:0] SPI_IDLE_BYTE = 8'hFF;
  typedef enum logic {ST_IDLE, ST_ACTIVE} spi_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer for SCLK plus auxiliary pins, with SCLK leading/trailing strobes
// Ports:
//   clk, rst          system clock, async active-high reset
//   sclk_i, inv_i     raw SPI clock and polarity (CPOL) used to normalize it
//   aux_i / aux_o     extra pins synchronized alongside SCLK (no edge detection)
//   lead_o, trail_o   one-cycle strobes on normalized 0->1 / 1->0 changes
module spi_sync_edge #(
  parameter int STAGES = 2,
  parameter int AUX_W = 1,
  parameter logic [AUX_W-1:0] AUX_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk_i,
  input  logic             inv_i,
  input  logic [AUX_W-1:0] aux_i,
  output logic [AUX_W-1:0] aux_o,
  output logic             lead_o,
  output logic             trail_o
);
  logic [STAGES-1:0][AUX_W:0] sync_q;
  logic norm_d, norm_q, lead_q, trail_q;
  assign norm_d = sync_q[STAGES-1][0] ^ inv_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= {STAGES{AUX_INIT, 1'b0}};
      norm_q <= 1'b0;
      lead_q <= 1'b0;
      trail_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], aux_i, sclk_i};
      norm_q <= norm_d;
      lead_q <= norm_d & ~norm_q;
      trail_q <= ~norm_d & norm_q;
    end
  assign aux_o = sync_q[STAGES-1][AUX_W:1];
  assign lead_o = lead_q;
  assign trail_o = trail_q;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: byte-oriented full-duplex MSB-first SPI slave oversampled on sys_clk
// Ports:
//   sys_clk, sys_rst                 system clock, async active-high reset
//   i_spi_clk, i_cs_n, i_mosi        SPI pins from the master (asynchronous)
//   i_clk_pol                        CPOL, changed only while CS is high
//   i_tx_vd, i_tx_parallel, o_tx_ready   single-entry transmit holding buffer handshake
//   o_miso, o_miso_oe                serial data and output enable toward the master
//   o_rx_parallel, o_rx_vd           last received byte and its one-cycle valid pulse
//   o_tx_underrun                    pulse when the idle byte was loaded for lack of data
//   o_bit_count                      bits received in the current byte
module spi_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE = SPI_IDLE_BYTE
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     i_spi_clk,
  input  logic                     i_cs_n,
  input  logic                     i_mosi,
  input  logic                     i_clk_pol,
  input  logic                     i_tx_vd,
  input  logic [SPI_BYTE_W-1:0]    i_tx_parallel,
  output logic                     o_tx_ready,
  output logic                     o_miso,
  output logic                     o_miso_oe,
  output logic [SPI_BYTE_W-1:0]    o_rx_parallel,
  output logic                     o_rx_vd,
  output logic                     o_tx_underrun,
  output logic [SPI_BIT_CNT_W-1:0] o_bit_count
);
  logic [1:0] aux_s;
  logic lead, trail, cs_s, mosi_s;
  spi_state_e state_q;
  logic [SPI_BYTE_W-1:0] buf_q, tx_sh_q, rx_sh_q, rx_par_q;
  logic [SPI_BIT_CNT_W-1:0] cnt_q;
  logic ready_q, miso_q, oe_q, rx_vd_q, under_q;
  // CS must come out of reset inactive, so its synchronizer resets to 1
  spi_sync_edge #(.STAGES(SYNC_STAGES), .AUX_W(2), .AUX_INIT(2'b01)) u_sync (
    .clk(sys_clk), .rst(sys_rst), .sclk_i(i_spi_clk), .inv_i(i_clk_pol),
    .aux_i({i_mosi, i_cs_n}), .aux_o(aux_s), .lead_o(lead), .trail_o(trail)
  );
  assign cs_s = aux_s[0];
  assign mosi_s = aux_s[1];
  // A write needs ready=1 and a byte-start consume needs ready=0, so the two
  // ready_q updates below never collide; the load never bypasses a same-cycle write.
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state_q <= ST_IDLE;
      buf_q <= '0;
      ready_q <= 1'b1;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      rx_par_q <= '0;
      cnt_q <= '0;
      miso_q <= 1'b0;
      oe_q <= 1'b0;
      rx_vd_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      rx_vd_q <= 1'b0;
      under_q <= 1'b0;
      if (i_tx_vd && ready_q) begin
        buf_q <= i_tx_parallel;
        ready_q <= 1'b0;
      end
      if (state_q == ST_IDLE) begin
        oe_q <= ~cs_s;
        miso_q <= 1'b0;
        cnt_q <= '0;
        if (!cs_s) state_q <= ST_ACTIVE;
      end else if (cs_s) begin
        state_q <= ST_IDLE;
        oe_q <= 1'b0;
        miso_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        if (lead && cnt_q == '0) begin
          tx_sh_q <= ready_q ? IDLE_BYTE : buf_q;
          miso_q <= ready_q ? IDLE_BYTE[SPI_BYTE_W-1] : buf_q[SPI_BYTE_W-1];
          under_q <= ready_q;
          if (!ready_q) ready_q <= 1'b1;
        end else if (lead) begin
          tx_sh_q <= {tx_sh_q[SPI_BYTE_W-2:0], 1'b0};
          miso_q <= tx_sh_q[SPI_BYTE_W-2];
        end
        if (trail) begin
          rx_sh_q <= {rx_sh_q[SPI_BYTE_W-2:0], mosi_s};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) begin
            rx_par_q <= {rx_sh_q[SPI_BYTE_W-2:0], mosi_s};
            rx_vd_q <= 1'b1;
          end
        end
      end
    end
  assign o_tx_ready = ready_q;
  assign o_miso = miso_q;
  assign o_miso_oe = oe_q;
  assign o_rx_parallel = rx_par_q;
  assign o_rx_vd = rx_vd_q;
  assign o_tx_underrun = under_q;
  assign o_bit_count = cnt_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: scoreboard bench driving a bit-level SPI master model against spi_slave
module tb_spi_slave;
  localparam int SS = 2;
  localparam int HMIN = SS + 2;
  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, cpol = 1'b0, tx_vd = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic o_tx_ready, o_miso, o_miso_oe, o_rx_vd, o_tx_underrun;
  logic [7:0] o_rx_parallel;
  logic [2:0] o_bit_count;
  int checks = 0, errors = 0, rx_cnt = 0, ur_cnt = 0, half = 6;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];

  always #5 clk = ~clk;

  spi_slave #(.SYNC_STAGES(SS)) dut (
    .sys_clk(clk), .sys_rst(rst), .i_spi_clk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
    .i_clk_pol(cpol), .i_tx_vd(tx_vd), .i_tx_parallel(tx_data), .o_tx_ready(o_tx_ready),
    .o_miso(o_miso), .o_miso_oe(o_miso_oe), .o_rx_parallel(o_rx_parallel), .o_rx_vd(o_rx_vd),
    .o_tx_underrun(o_tx_underrun), .o_bit_count(o_bit_count)
  );

  always @(negedge clk)
    if (!rst) begin
      if (o_tx_underrun) ur_cnt++;
      if (o_rx_vd) begin
        rx_cnt++;
        checks++;
        if (rxq.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: got %h with no byte expected", o_rx_parallel);
        end else begin
          logic [7:0] e;
          e = rxq.pop_front();
          if (o_rx_parallel !== e) begin
            errors++;
            $display("FAIL rx_data: got %h expected %h", o_rx_parallel, e);
          end
        end
      end
    end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_start;
    cs_n = 1'b0;
    tick(half);
  endtask

  task automatic spi_stop;
    cs_n = 1'b1;
    tick(2 * half);
  endtask

  task automatic spi_byte(input logic [7:0] b, input int nbits);
    logic [7:0] got, e;
    got = '0;
    if (nbits == 8) rxq.push_back(b);
    for (int i = 0; i < nbits; i++) begin
      sclk = ~cpol;
      mosi = b[7-i];
      tick(half);
      got = {got[6:0], o_miso};
      sclk = cpol;
      tick(half);
    end
    checks++;
    if (txq.size() == 0) begin
      errors++;
      $display("FAIL miso_no_expect: got %h", got);
    end else begin
      e = txq.pop_front() >> (8 - nbits);
      if (got !== e) begin
        errors++;
        $display("FAIL miso_data: got %h expected %h (%0d bits)", got, e, nbits);
      end
    end
  endtask

  task automatic write_tx(input logic [7:0] d);
    int n;
    n = 0;
    while (!o_tx_ready && n < 500) begin
      tick(1);
      n++;
    end
    if (!o_tx_ready) begin
      checks++;
      errors++;
      $display("FAIL tx_ready_timeout: got ready=%b expected 1", o_tx_ready);
    end else begin
      tx_data = d;
      tx_vd = 1'b1;
      tick(1);
      tx_vd = 1'b0;
      txq.push_back(d);
    end
  endtask

  task automatic test_reset;
    tick(3);
    checks++;
    if ({o_tx_ready, o_miso, o_miso_oe, o_rx_vd, o_tx_underrun} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 10000", {o_tx_ready, o_miso, o_miso_oe, o_rx_vd, o_tx_underrun});
    end
    checks++;
    if ({o_rx_parallel, o_bit_count} !== 11'd0) begin
      errors++;
      $display("FAIL reset_data: got rx=%h cnt=%0d expected 0", o_rx_parallel, o_bit_count);
    end
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_basic;
    int rx0;
    rx0 = rx_cnt;
    write_tx(8'hA5);
    checks++;
    if (o_tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready_full: got %b expected 0", o_tx_ready);
    end
    spi_start;
    checks++;
    if (o_miso_oe !== 1'b1 || o_miso !== 1'b0) begin
      errors++;
      $display("FAIL basic_oe: got oe=%b miso=%b expected oe=1 miso=0", o_miso_oe, o_miso);
    end
    spi_byte(8'h3C, 8);
    checks++;
    if (o_tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready_back: got %b expected 1", o_tx_ready);
    end
    spi_stop;
    checks++;
    if (rx_cnt - rx0 != 1 || o_rx_parallel !== 8'h3C) begin
      errors++;
      $display("FAIL basic_rx: got %0d pulses data %h expected 1 pulse data 3c", rx_cnt - rx0, o_rx_parallel);
    end
  endtask

  task automatic test_back_to_back;
    int rx0;
    cpol = 1'b1;
    sclk = 1'b1;
    tick(4);
    rx0 = rx_cnt;
    write_tx(8'h81);
    spi_start;
    fork
      spi_byte(8'hF0, 8);
      write_tx(8'h7E);
    join
    spi_byte(8'h0F, 8);
    spi_stop;
    checks++;
    if (rx_cnt - rx0 != 2 || o_rx_parallel !== 8'h0F) begin
      errors++;
      $display("FAIL b2b_rx: got %0d pulses last %h expected 2 pulses last 0f", rx_cnt - rx0, o_rx_parallel);
    end
    cpol = 1'b0;
    sclk = 1'b0;
    tick(4);
  endtask

  task automatic test_underrun;
    int ur0;
    ur0 = ur_cnt;
    txq.push_back(8'hFF);
    spi_start;
    spi_byte(8'h55, 8);
    checks++;
    if (ur_cnt - ur0 != 1) begin
      errors++;
      $display("FAIL underrun_count: got %0d expected 1", ur_cnt - ur0);
    end
    txq.push_back(8'hFF);
    fork
      spi_byte(8'hAA, 8);
      begin
        // lands on the same sys_clk edge as the byte-start load
        repeat (3) @(posedge clk);
        #1;
        tx_data = 8'hC7;
        tx_vd = 1'b1;
        tick(1);
        tx_vd = 1'b0;
        txq.push_back(8'hC7);
        checks++;
        if (o_tx_ready !== 1'b0 || o_tx_underrun !== 1'b1) begin
          errors++;
          $display("FAIL coincident_write: got ready=%b underrun=%b expected ready=0 underrun=1", o_tx_ready, o_tx_underrun);
        end
      end
    join
    spi_byte(8'hC3, 8);
    spi_stop;
    checks++;
    if (ur_cnt - ur0 != 2) begin
      errors++;
      $display("FAIL underrun_total: got %0d expected 2", ur_cnt - ur0);
    end
  endtask

  task automatic test_abort;
    int rx0;
    rx0 = rx_cnt;
    txq.push_back(8'hFF);
    spi_start;
    spi_byte(8'hB2, 5);
    checks++;
    if (o_bit_count !== 3'd5) begin
      errors++;
      $display("FAIL abort_partial_count: got %0d expected 5", o_bit_count);
    end
    write_tx(8'h5A);
    spi_stop;
    checks++;
    if (rx_cnt != rx0 || o_bit_count !== 3'd0 || o_miso_oe !== 1'b0 || o_tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: got pulses=%0d cnt=%0d oe=%b ready=%b expected 0 0 0 0", rx_cnt - rx0, o_bit_count, o_miso_oe, o_tx_ready);
    end
    spi_start;
    spi_byte(8'hD4, 8);
    spi_stop;
    checks++;
    if (rx_cnt - rx0 != 1 || o_rx_parallel !== 8'hD4) begin
      errors++;
      $display("FAIL abort_recover: got %0d pulses data %h expected 1 pulse data d4", rx_cnt - rx0, o_rx_parallel);
    end
  endtask

  task automatic test_reset_mid;
    write_tx(8'hC3);
    spi_start;
    spi_byte(8'hE1, 3);
    write_tx(8'h11);
    rst = 1'b1;
    #1;
    checks++;
    if ({o_tx_ready, o_miso, o_miso_oe, o_rx_vd, o_tx_underrun} !== 5'b10000 || {o_rx_parallel, o_bit_count} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid: got flags=%b rx=%h cnt=%0d expected 10000 00 0",
               {o_tx_ready, o_miso, o_miso_oe, o_rx_vd, o_tx_underrun}, o_rx_parallel, o_bit_count);
    end
    cs_n = 1'b1;
    sclk = cpol;
    txq.delete();
    rxq.delete();
    tick(3);
    rst = 1'b0;
    tick(3);
    write_tx(8'h96);
    spi_start;
    spi_byte(8'h69, 8);
    spi_stop;
    checks++;
    if (o_rx_parallel !== 8'h69) begin
      errors++;
      $display("FAIL reset_recover: got %h expected 69", o_rx_parallel);
    end
  endtask

  task automatic test_min_rate;
    int rx0;
    logic [7:0] b, nxt;
    half = HMIN;
    rx0 = rx_cnt;
    write_tx(8'($urandom));
    spi_start;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      nxt = 8'($urandom);
      if (i < 255)
        fork
          spi_byte(b, 8);
          write_tx(nxt);
        join
      else
        spi_byte(b, 8);
    end
    spi_stop;
    checks++;
    if (rx_cnt - rx0 != 256 || rxq.size() != 0 || txq.size() != 0) begin
      errors++;
      $display("FAIL min_rate: got %0d pulses rxq=%0d txq=%0d expected 256 0 0", rx_cnt - rx0, rxq.size(), txq.size());
    end
    half = 6;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_underrun;
    test_abort;
    test_reset_mid;
    test_min_rate;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Byte-oriented SPI slave, full duplex, MSB-first, oversampled on sys_clk. It is the far-end peer of the team's SPI master and lets a peer device or loopback bench answer that master.
- All SPI pins are synchronized into the sys_clk domain. MOSI is sampled on the trailing SPI edge and MISO is driven on the leading edge, matching the master's timing (master drives on leading, samples on trailing).
- Transmit side: single-entry holding buffer with a valid/ready handshake. Receive side: one-cycle valid pulse per received byte.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for i_spi_clk, i_cs_n and i_mosi (minimum 2).
- IDLE_BYTE, 8'hFF, byte shifted out when the holding buffer is empty at byte start.

Ports:
- sys_clk  in  1  system clock; all logic is in this domain.
- sys_rst  in  1  asynchronous, active-high reset.
- i_spi_clk  in  1  SPI clock from the master (asynchronous to sys_clk).
- i_cs_n  in  1  chip select, active-low (asynchronous).
- i_mosi  in  1  serial data from the master.
- i_clk_pol  in  1  CPOL; quasi-static, changed only while i_cs_n is high.
- i_tx_vd  in  1  tx data valid.
- i_tx_parallel  in  8  byte to send.
- o_tx_ready  out  1  holding buffer empty; a write is accepted when i_tx_vd && o_tx_ready.
- o_miso  out  1  serial data to the master.
- o_miso_oe  out  1  MISO output enable, high while the synchronized CS is active.
- o_rx_parallel  out  8  last complete received byte.
- o_rx_vd  out  1  one-cycle pulse when o_rx_parallel updates.
- o_tx_underrun  out  1  one-cycle pulse when IDLE_BYTE was loaded.
- o_bit_count  out  3  bits received in the current byte.

Behaviour:
- Reset values (asynchronous): o_tx_ready=1, o_miso=0, o_miso_oe=0, o_rx_parallel=0, o_rx_vd=0, o_tx_underrun=0, o_bit_count=0. The holding buffer, both shift registers and all synchronizers clear; the synchronized CS resets to 1 (inactive).
- Sync and edge detect: each pin passes through SYNC_STAGES flops. Normalized clock = synced SCLK XOR i_clk_pol. A 0->1 change of the normalized clock is a leading edge; a 1->0 change is a trailing edge. Each detected edge is a one-cycle strobe.
- Latency: strobe fires SYNC_STAGES+1 sys_clk cycles after the pin edge.
- Rate requirement: each SPI clock half-period must be at least SYNC_STAGES+2 sys_clk cycles.
- States:
  - IDLE: synced CS high. o_miso_oe=0, o_miso=0, o_bit_count=0, edges ignored.
  - ACTIVE: entered on synced CS falling. o_miso_oe=1 and o_miso=0 until the first leading edge.
  - ACTIVE -> IDLE: on synced CS rising, at any time.
- Leading edge, o_bit_count==0 (byte start):
  - tx shift register loads from the holding buffer if full; the buffer empties and o_tx_ready rises next cycle.
  - If the buffer is empty, it loads IDLE_BYTE and pulses o_tx_underrun.
  - o_miso = bit 7 of the loaded byte.
- Leading edge, o_bit_count!=0: tx shift register shifts left; o_miso = the new MSB.
- Trailing edge:
  - rx_shift <= {rx_shift[6:0], synced mosi}; o_bit_count increments with mod-8 wrap.
  - On the 7->0 wrap: o_rx_parallel <= the completed byte and o_rx_vd pulses in the following cycle.
  - No receive handshake: an unread byte is overwritten by the next one.
- Holding buffer write: when i_tx_vd && o_tx_ready, the buffer captures i_tx_parallel and o_tx_ready drops next cycle. Writes while ready=0 are ignored.
- Write in the same cycle as a byte-start load: no bypass. The load sees the empty buffer (IDLE_BYTE sent, underrun pulses) and the write fills the buffer for the next byte.
- CS deasserted mid-byte: partial rx bits are discarded with no o_rx_vd, o_bit_count=0, and the tx shift register is discarded. A full holding buffer is retained for the next transaction.
- Reset mid-transfer: everything returns to reset values immediately, and any pending tx byte is lost.

Decomposition:
- Shared package spi_pkg:
  - SPI_BYTE_W=8 and SPI_BIT_CNT_W=3.
  - State encoding (IDLE, ACTIVE).
  - Default IDLE_BYTE constant.
- One natural sub-module, spi_sync_edge: a parameterized synchronizer plus edge detector producing the synced level and the leading/trailing strobes. It is instantiated for SCLK; CS and MOSI reuse its synchronizer only.

Test Plan:
- Basic full duplex, CPOL=0: write 8'hA5 to the buffer, master sends 8'h3C → MISO bits 1,0,1,0,0,1,0,1 at the master's trailing edges; o_rx_parallel=8'h3C with one o_rx_vd pulse; o_tx_ready back to 1 after the first leading edge.
- CPOL=1, two back-to-back bytes: write 8'h81, then 8'h7E once ready rises; master sends 8'hF0, 8'h0F → master receives 8'h81, 8'h7E; exactly two o_rx_vd pulses carrying 8'hF0 then 8'h0F.
- Underrun: no write, master clocks one byte → MISO returns 8'hFF and o_tx_underrun pulses once. A write that coincides with the byte-start load is sent on the following byte.
- CS abort: deassert CS after 5 trailing edges → no o_rx_vd, o_bit_count=0, o_miso_oe=0. The next full transaction receives correctly and sends the retained holding byte.
- Reset mid-byte: assert sys_rst after 3 bits → all outputs at reset values within the same cycle, o_tx_ready=1. A clean transfer after release succeeds.
- Minimum rate: run the SPI half-period at exactly SYNC_STAGES+2 sys_clk cycles with random bytes over 256 transfers → no data mismatches and no missed or duplicate o_rx_vd pulses.
